// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared UART definitions: receiver state encoding, parity-mode constants
//   and small helpers. Also meant to be used by the future TX block.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_rx_state_e;

  // Value XORed onto the data parity to obtain the parity bit on the wire.
  localparam logic UART_PARITY_EVEN = 1'b0;
  localparam logic UART_PARITY_ODD  = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Expected parity bit for a word whose bits XOR to data_xor.
  function automatic logic uart_parity_expected(input logic data_xor, input logic odd);
    return data_xor ^ (odd ? UART_PARITY_ODD : UART_PARITY_EVEN);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler
//   Two-flop synchroniser for the asynchronous rxd pad plus a 2-of-3 majority
//   voter over the samples taken at ticks MID-1, MID and MID+1 of each bit.
// Ports
//   clk, rst   clock, synchronous active-high reset
//   rxd        asynchronous serial input (idle high)
//   rx_en      oversample tick
//   tick_cnt   current tick position within the bit (from the FSM)
//   rxd_s      synchronised rxd
//   bit_val    majority value; valid on the tick where tick_cnt == MID+1
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int TICK_W     = $clog2(OVERSAMPLE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  input  logic              rx_en,
  input  logic [TICK_W-1:0] tick_cnt,
  output logic              rxd_s,
  output logic              bit_val
);

  localparam int MID = OVERSAMPLE / 2;

  logic rxd_meta_q, rxd_meta_d;
  logic rxd_s_q,    rxd_s_d;
  logic samp_a_q,   samp_a_d;
  logic samp_b_q,   samp_b_d;

  always_comb begin
    rxd_meta_d = rxd;
    rxd_s_d    = rxd_meta_q;
    samp_a_d   = samp_a_q;
    samp_b_d   = samp_b_q;
    if (rx_en && (tick_cnt == TICK_W'(MID - 1))) samp_a_d = rxd_s_q;
    if (rx_en && (tick_cnt == TICK_W'(MID)))     samp_b_d = rxd_s_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      samp_a_q   <= 1'b1;
      samp_b_q   <= 1'b1;
    end else begin
      rxd_meta_q <= rxd_meta_d;
      rxd_s_q    <= rxd_s_d;
      samp_a_q   <= samp_a_d;
      samp_b_q   <= samp_b_d;
    end
  end

  assign rxd_s = rxd_s_q;
  // Third vote is the live synchronised value at tick MID+1.
  assign bit_val = maj3(samp_a_q, samp_b_q, rxd_s_q);

endmodule

// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled
//   UART receiver driven by an oversample tick. Detects start bits, votes each
//   bit at mid-bit, checks optional parity and the stop bit, and presents the
//   word through a one-entry valid/ready holding register.
// Ports
//   clk, rst    clock, synchronous active-high reset
//   rx_en       oversample tick (OVERSAMPLE per bit)
//   rxd         asynchronous serial input, idle high
//   rx_data     received word, stable while rx_valid
//   rx_valid    word available
//   rx_ready    consumer accepts when rx_valid && rx_ready
//   frame_err   stop bit sampled low (qualifies rx_data)
//   parity_err  parity mismatch (qualifies rx_data)
//   overrun     sticky: a completed frame was dropped; cleared on handshake
//   busy        FSM not idle
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a low line on a tick (only while armed)
// START  | validating start bit; high majority at mid-bit = glitch
// DATA   | shifting data bits in, LSB first
// PARITY | sampling the parity bit (PARITY_EN only)
// STOP   | stop bit decided at mid-bit, then straight back to IDLE
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_en,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam int MID    = OVERSAMPLE / 2;

  uart_rx_state_e       state_q, state_d;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 armed_q, armed_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;

  logic rxd_s;
  logic bit_val;
  logic tick_dec;
  logic tick_last;
  logic complete;
  logic stop_ferr;
  logic handshake;

  uart_rx_sampler #(
    .OVERSAMPLE (OVERSAMPLE),
    .TICK_W     (TICK_W)
  ) u_sampler (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .rx_en    (rx_en),
    .tick_cnt (tick_cnt_q),
    .rxd_s    (rxd_s),
    .bit_val  (bit_val)
  );

  assign tick_dec  = (tick_cnt_q == TICK_W'(MID + 1));
  assign tick_last = (tick_cnt_q == TICK_W'(OVERSAMPLE - 1));
  assign handshake = rx_valid_q && rx_ready;

  // Receive FSM, counters and shift register.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    armed_d    = armed_q;
    complete   = 1'b0;
    stop_ferr  = 1'b0;

    unique case (state_q)
      IDLE: begin
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
        // After a break the line must return high before a new start counts.
        if (!armed_q && rxd_s) armed_d = 1'b1;
        if (rx_en && armed_q && !rxd_s) begin
          state_d = START;
          perr_d  = 1'b0;
        end
      end
      START: begin
        if (rx_en) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
          if (tick_dec && bit_val) begin
            state_d    = IDLE;
            tick_cnt_d = '0;
          end else if (tick_last) begin
            state_d    = DATA;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
          end
        end
      end
      DATA: begin
        if (rx_en) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
          if (tick_dec) shift_d[bit_cnt_q] = bit_val;
          if (tick_last) begin
            tick_cnt_d = '0;
            if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
              bit_cnt_d = '0;
              state_d   = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
      end
      PARITY: begin
        if (rx_en) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
          if (tick_dec)
            perr_d = (bit_val != uart_parity_expected(^shift_q, PARITY_ODD != 0));
          if (tick_last) begin
            state_d    = STOP;
            tick_cnt_d = '0;
          end
        end
      end
      STOP: begin
        if (rx_en) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
          // Decide at mid-bit so a back-to-back start edge is not missed.
          if (tick_dec) begin
            complete   = 1'b1;
            stop_ferr  = !bit_val;
            state_d    = IDLE;
            tick_cnt_d = '0;
            if (!bit_val && (shift_q == '0)) armed_d = 1'b0;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
      end
    endcase
  end

  // Output holding register and overrun tracking.
  always_comb begin
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    overrun_d    = overrun_q;

    if (complete) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d    = shift_q;
        frame_err_d  = stop_ferr;
        parity_err_d = (PARITY_EN != 0) ? perr_q : 1'b0;
        rx_valid_d   = 1'b1;
        if (handshake) overrun_d = 1'b0;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (handshake) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      armed_q      <= 1'b1;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      armed_q      <= armed_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
module tb_uart_rx_oversampled;

  localparam int BIT_CLK = 64;   // rx_en every 4 clk, 16 ticks per bit

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_en = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, overrun, busy;

  logic       rxd_p = 1'b1;
  logic       rx_ready_p = 1'b1;
  logic [7:0] rx_data_p;
  logic       rx_valid_p, frame_err_p, parity_err_p, overrun_p, busy_p;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;
  exp_t exp_q[$];

  // Literal capture of the last delivered word on each instance.
  int         m_cnt = 0;
  logic [7:0] m_data = '0;
  logic       m_ferr = 1'b0;
  int         p_cnt = 0;
  logic [7:0] p_data = '0;
  logic       p_perr = 1'b0;
  logic       p_ferr = 1'b0;

  uart_rx_oversampled #(
    .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)
  ) dut (
    .clk(clk), .rst(rst), .rx_en(rx_en), .rxd(rxd),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun), .busy(busy)
  );

  uart_rx_oversampled #(
    .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)
  ) dut_p (
    .clk(clk), .rst(rst), .rx_en(rx_en), .rxd(rxd_p),
    .rx_data(rx_data_p), .rx_valid(rx_valid_p), .rx_ready(rx_ready_p),
    .frame_err(frame_err_p), .parity_err(parity_err_p), .overrun(overrun_p), .busy(busy_p)
  );

  always #5 clk = ~clk;

  initial begin : tick_gen
    int unsigned cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      cnt = cnt + 1;
      rx_en = (cnt % 4 == 0);
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Scoreboard: any held word must equal the oldest expected word.
  always @(negedge clk) begin
    if (!rst && rx_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got data=0x%0h ferr=%0b, expected no word (t=%0t)",
                 rx_data, frame_err, $time);
      end else begin
        chk("rx_data", int'(rx_data), int'(exp_q[0].data));
        chk("frame_err", int'(frame_err), int'(exp_q[0].ferr));
        chk("parity_err", int'(parity_err), int'(exp_q[0].perr));
        if (rx_ready) void'(exp_q.pop_front());
      end
    end
    if (!rst && rx_valid && rx_ready) begin
      m_cnt++;
      m_data = rx_data;
      m_ferr = frame_err;
    end
    if (!rst && rx_valid_p && rx_ready_p) begin
      p_cnt++;
      p_data = rx_data_p;
      p_perr = parity_err_p;
      p_ferr = frame_err_p;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input bit which, input logic v);
    if (which) rxd_p = v;
    else rxd = v;
  endtask

  task automatic idle(input bit which, input int n);
    set_line(which, 1'b1);
    wait_clk(n);
  endtask

  // Drives start, 8 data bits LSB first, optional parity, stop. Line is left
  // at the stop level.
  task automatic send_frame(input bit which, input logic [7:0] d, input bit use_par,
                            input logic par, input logic stop);
    set_line(which, 1'b0);
    wait_clk(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      set_line(which, d[i]);
      wait_clk(BIT_CLK);
    end
    if (use_par) begin
      set_line(which, par);
      wait_clk(BIT_CLK);
    end
    set_line(which, stop);
    wait_clk(BIT_CLK);
  endtask

  task automatic expect_word(input logic [7:0] d, input logic ferr);
    exp_t e;
    e.data = d;
    e.ferr = ferr;
    e.perr = 1'b0;
    exp_q.push_back(e);
  endtask

  initial begin : stim
    int m0;
    int p0;
    logic [7:0] d;
    logic stop;

    wait_clk(3);
    chk("reset_rx_data", int'(rx_data), 0);
    chk("reset_rx_valid", int'(rx_valid), 0);
    chk("reset_frame_err", int'(frame_err), 0);
    chk("reset_parity_err", int'(parity_err), 0);
    chk("reset_overrun", int'(overrun), 0);
    chk("reset_busy", int'(busy), 0);
    rst = 1'b0;
    wait_clk(2 * BIT_CLK);

    // 8N1 0xA5, consumer always ready.
    m0 = m_cnt;
    expect_word(8'hA5, 1'b0);
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    idle(1'b0, BIT_CLK);
    chk("a5_count", m_cnt - m0, 1);
    chk("a5_data", int'(m_data), 'hA5);
    chk("a5_ferr", int'(m_ferr), 0);

    // Short low glitch: start rejected, nothing delivered.
    set_line(1'b0, 1'b0);
    wait_clk(12);
    chk("glitch_busy_during", int'(busy), 1);
    wait_clk(4);
    idle(1'b0, BIT_CLK);
    chk("glitch_busy_after", int'(busy), 0);
    idle(1'b0, BIT_CLK);

    // Framing error, then a held-low line forms one break frame only.
    m0 = m_cnt;
    expect_word(8'h3C, 1'b1);
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    expect_word(8'h00, 1'b1);
    wait_clk(20 * BIT_CLK);
    chk("break_busy", int'(busy), 0);
    chk("break_count", m_cnt - m0, 2);
    chk("break_data", int'(m_data), 0);
    chk("break_ferr", int'(m_ferr), 1);
    idle(1'b0, 2 * BIT_CLK);
    expect_word(8'h81, 1'b0);
    send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
    idle(1'b0, BIT_CLK);
    chk("rearm_data", int'(m_data), 'h81);

    // Parity instance, even parity: ^0x07 = 1 so bit 0 is a mismatch.
    p0 = p_cnt;
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    idle(1'b1, BIT_CLK);
    chk("par_cnt0", p_cnt - p0, 1);
    chk("par_data0", int'(p_data), 'h07);
    chk("par_perr0", int'(p_perr), 1);
    chk("par_ferr0", int'(p_ferr), 0);
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    idle(1'b1, BIT_CLK);
    chk("par_perr1", int'(p_perr), 0);
    send_frame(1'b1, 8'h03, 1'b1, 1'b0, 1'b1);
    idle(1'b1, BIT_CLK);
    chk("par_data2", int'(p_data), 'h03);
    chk("par_perr2", int'(p_perr), 0);
    chk("par_cnt2", p_cnt - p0, 3);

    // Overrun: consumer stalled, second frame dropped.
    rx_ready = 1'b0;
    expect_word(8'h11, 1'b0);
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    idle(1'b0, BIT_CLK);
    chk("ovr_before", int'(overrun), 0);
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    idle(1'b0, BIT_CLK);
    chk("ovr_set", int'(overrun), 1);
    chk("ovr_valid", int'(rx_valid), 1);
    chk("ovr_held", int'(rx_data), 'h11);
    rx_ready = 1'b1;
    wait_clk(1);
    chk("ovr_cleared", int'(overrun), 0);
    chk("ovr_valid_low", int'(rx_valid), 0);
    idle(1'b0, BIT_CLK);

    // Reset mid-frame with a held word, framing error and overrun pending.
    rx_ready = 1'b0;
    expect_word(8'h33, 1'b1);
    send_frame(1'b0, 8'h33, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 2 * BIT_CLK);
    send_frame(1'b0, 8'h44, 1'b0, 1'b0, 1'b1);
    idle(1'b0, BIT_CLK);
    chk("pre_rst_overrun", int'(overrun), 1);
    d = 8'h5A;
    set_line(1'b0, 1'b0);
    wait_clk(BIT_CLK);
    for (int i = 0; i < 3; i++) begin
      set_line(1'b0, d[i]);
      wait_clk(BIT_CLK);
    end
    set_line(1'b0, d[3]);
    wait_clk(BIT_CLK / 2);
    chk("pre_rst_busy", int'(busy), 1);
    rst = 1'b1;
    exp_q.delete();
    wait_clk(1);
    chk("rst_rx_data", int'(rx_data), 0);
    chk("rst_rx_valid", int'(rx_valid), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_parity_err", int'(parity_err), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    rx_ready = 1'b1;
    idle(1'b0, 3 * BIT_CLK);
    m0 = m_cnt;
    expect_word(8'h5A, 1'b0);
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    idle(1'b0, BIT_CLK);
    chk("post_rst_count", m_cnt - m0, 1);
    chk("post_rst_data", int'(m_data), 'h5A);

    // Randomized frames: payload, stop-bit errors, start phase and gaps.
    for (int n = 0; n < 30; n++) begin
      d = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 7) != 0);
      expect_word(d, !stop);
      wait_clk($urandom_range(0, 3));
      send_frame(1'b0, d, 1'b0, 1'b0, stop);
      idle(1'b0, BIT_CLK + $urandom_range(0, 136));
    end

    wait_clk(10);
    chk("queue_drained", exp_q.size(), 0);
    chk("final_overrun", int'(overrun), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
